mem_req_issuer: RTL

//  Upstream feeder of the memory-request delay line. Accepts pipeline memory requests on a

---
 rtl/mem_req_issuer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mem_req_issuer.sv
// rtl/mem_req_issuer.sv - request issuer feeding the memory delay line, with tagged read returns
// Optional read/write statistics counters: MEM_REQ_ISSUER_STATS_EN.
module mem_req_issuer #(
    parameter int n       = 8,
    parameter int m       = 32,
    parameter int delay   = 4,
    parameter int RD_LAT  = 5,
    parameter int TAGW    = 4,
    parameter int MAX_OUT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_rw,
    input  logic            req_clr,
    input  logic [n-1:0]    req_addr,
    input  logic [m-1:0]    req_wdata,
    input  logic [TAGW-1:0] req_tag,
    output logic [n-1:0]    marO,
    output logic [m-1:0]    dataO,
    output logic            ceO,
    output logic            rwO,
    output logic            clrO,
    input  logic [m-1:0]    mem_rdata,
    output logic            rsp_valid,
    output logic [m-1:0]    rsp_data,
    output logic [TAGW-1:0] rsp_tag,
    output logic            busy,
    output logic [15:0]     rd_cnt,
    output logic [15:0]     wr_cnt
);
    localparam int OUTW = $clog2(MAX_OUT + 1);
    localparam int CNTW = $clog2(delay + 2);

    typedef enum logic [1:0] {RUN, DRAIN, CLRHOLD} stateT;

    stateT             state;
    logic [OUTW-1:0]   outstanding;
    logic [CNTW-1:0]   holdCnt;
    logic [RD_LAT-1:0] pipeValid;
    logic [TAGW-1:0]   pipeTag [RD_LAT];
    logic              accept;
    logic              readIssue;
    logic              retire;

    always_comb begin
        req_ready = (state == RUN)
                    && !(req_rw && !req_clr && outstanding == OUTW'(MAX_OUT))
                    && !(req_clr && outstanding != '0);
        accept    = req_valid && req_ready;
        readIssue = accept && !req_clr && req_rw;
        retire    = pipeValid[RD_LAT-1];
    end

    assign busy = (outstanding != '0) || (state != RUN);

    // Tags ride alongside the valid bits; only the valid bits need clearing on reset.
    always_ff @(posedge clk) begin
        pipeTag[0] <= req_tag;
        for (int i = 1; i < RD_LAT; i++) begin
            pipeTag[i] <= pipeTag[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            outstanding <= '0;
            holdCnt     <= '0;
            pipeValid   <= '0;
            marO        <= '0;
            dataO       <= '0;
            ceO         <= 1'b0;
            rwO         <= 1'b0;
            clrO        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_tag     <= '0;
        end else begin
            pipeValid[0] <= readIssue;
            for (int i = 1; i < RD_LAT; i++) begin
                pipeValid[i] <= pipeValid[i-1];
            end

            case ({readIssue, retire})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase

            ceO  <= accept;
            clrO <= accept && req_clr;
            rwO  <= accept && !req_clr && req_rw;
            if (accept && !req_clr) begin
                marO  <= req_addr;
                dataO <= req_wdata;
            end

            rsp_valid <= retire;
            if (retire) begin
                rsp_data <= mem_rdata;
                rsp_tag  <= pipeTag[RD_LAT-1];
            end

            // A clear waits in DRAIN until every read has returned, then is taken in RUN.
            case (state)
                RUN: begin
                    if (accept && req_clr) begin
                        state   <= CLRHOLD;
                        holdCnt <= CNTW'(delay + 1);
                    end else if (req_valid && req_clr && outstanding != '0) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (outstanding == '0) state <= RUN;
                end
                CLRHOLD: begin
                    holdCnt <= holdCnt - 1'b1;
                    if (holdCnt == CNTW'(1)) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef MEM_REQ_ISSUER_STATS_EN
    logic [15:0] rdCntQ;
    logic [15:0] wrCntQ;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdCntQ <= '0;
            wrCntQ <= '0;
        end else if (accept && !req_clr) begin
            if (req_rw) rdCntQ <= rdCntQ + 16'd1;
            else        wrCntQ <= wrCntQ + 16'd1;
        end
    end

    assign rd_cnt = rdCntQ;
    assign wr_cnt = wrCntQ;
`else
    assign rd_cnt = '0;
    assign wr_cnt = '0;
`endif
endmodule
